pwm_capture: RTL

//   Receive-side companion to the on-chip PWM generator: measures an incoming PWM

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_sync_edge.sv | 38 +++
 rtl/pwm_capture.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// SPEED_W is common to both ends so speed codes match end to end.
package pwm_pkg;

    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, followed by a single
// delay flop used to detect rising and falling edges of the synchronised level.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_dly_q;
    logic                   s_dly_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform, quantises the
// duty cycle into a speed code, and flags a lost or stuck input via timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               pwm_in,
    output logic [CNT_W-1:0]   high_count,
    output logic [CNT_W-1:0]   period_count,
    output logic [SPEED_W-1:0] speed,
    output logic               valid,
    output logic               timeout
);

    localparam int             PROD_W    = CNT_W + 3;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic s;
    logic rise;
    logic fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock (clock),
        .reset (reset),
        .pwm_in(pwm_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]   high_count_q, high_count_d;
    logic [CNT_W-1:0]   period_count_q, period_count_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x >= TIMEOUT_C) ? TIMEOUT_C : x + 1'b1;
    endfunction

    // Duty quantiser: bit k-1 set when 8*high >= k*period, full-width products.
    logic [PROD_W-1:0]  hi_x8;
    logic [6:0]         k_ge;
    logic [SPEED_W-1:0] speed_calc;

    assign hi_x8 = {hi_cnt_q, 3'b000};

    generate
        for (genvar gi = 1; gi <= 7; gi++) begin : g_quant
            assign k_ge[gi-1] = hi_x8 >= (PROD_W'(gi) * PROD_W'(per_cnt_q));
        end
    endgenerate

    always_comb begin
        speed_calc = '0;
        for (int i = 0; i < 7; i++) begin
            speed_calc = speed_calc + SPEED_W'(k_ge[i]);
        end
    end

    logic tmo_hit;
    assign tmo_hit = (per_cnt_q >= TIMEOUT_C);

    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        per_cnt_d      = per_cnt_q;
        high_count_d   = high_count_q;
        period_count_d = period_count_q;
        speed_d        = speed_q;
        valid_d        = 1'b0;
        timeout_d      = timeout_q;

        if (!enable) begin
            state_d   = IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
                ARM: begin
                    if (rise) begin
                        hi_cnt_d  = CNT_W'(1);
                        per_cnt_d = CNT_W'(1);
                        state_d   = HIGH;
                    end else if (tmo_hit) begin
                        timeout_d = 1'b1;
                        speed_d   = s ? '1 : '0;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                HIGH: begin
                    if (tmo_hit) begin
                        timeout_d = 1'b1;
                        speed_d   = s ? '1 : '0;
                        state_d   = ARM;
                    end else if (fall) begin
                        per_cnt_d = sat_inc(per_cnt_q);
                        state_d   = LOW;
                    end else begin
                        hi_cnt_d  = sat_inc(hi_cnt_q);
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                LOW: begin
                    if (rise) begin
                        // Counters hold the just-completed period on this cycle.
                        high_count_d   = hi_cnt_q;
                        period_count_d = per_cnt_q;
                        speed_d        = speed_calc;
                        valid_d        = 1'b1;
                        timeout_d      = 1'b0;
                        hi_cnt_d       = CNT_W'(1);
                        per_cnt_d      = CNT_W'(1);
                        state_d        = HIGH;
                    end else if (tmo_hit) begin
                        timeout_d = 1'b1;
                        speed_d   = s ? '1 : '0;
                        state_d   = ARM;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            hi_cnt_q       <= '0;
            per_cnt_q      <= '0;
            high_count_q   <= '0;
            period_count_q <= '0;
            speed_q        <= '0;
            valid_q        <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            per_cnt_q      <= per_cnt_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            speed_q        <= speed_d;
            valid_q        <= valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign speed        = speed_q;
    assign valid        = valid_q;
    assign timeout      = timeout_q;

endmodule
